// File: rtl/cpu_defs.sv
// Shared definitions for the execute stage: ALU op codes, mult/div encodings,
// HI/LO move selects, the EX/MEM record and the ALU evaluation function.
package cpu_defs;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10
   } alu_op_e;

   // Bit 2 marks a mult/div, bit 1 selects divide, bit 0 selects unsigned.
   typedef enum logic [2:0] {
      MD_NONE  = 3'b000,
      MD_MULT  = 3'b100,
      MD_MULTU = 3'b101,
      MD_DIV   = 3'b110,
      MD_DIVU  = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MF_ALU = 2'b00,
      MF_HI  = 2'b01,
      MF_LO  = 2'b10
   } mf_sel_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [31:0] alu_s;
      logic [31:0] wdata;
      logic [4:0]  write_reg;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic [1:0]  mem_to_reg;
      logic [31:0] pc_plus4;
      logic        lu_op;
      logic [31:0] lu_data;
   } ex_mem_t;

   // A bubble carries no side effects and all-zero data.
   localparam ex_mem_t EX_MEM_BUBBLE = '0;

   // 32-bit ALU with wrap-around arithmetic; shifts move b by a[4:0].
   function automatic logic [31:0] alu_eval(input logic [3:0]  fun,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] y;
      y = '0;
      case (fun)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_NOR:  y = ~(a | b);
         ALU_SLL:  y = b << a[4:0];
         ALU_SRL:  y = b >> a[4:0];
         ALU_SRA:  y = 32'($signed(b) >>> a[4:0]);
         ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'd0, a < b};
         default:  y = '0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one bus.
// The master side is the pipeline control feeding the stage; the slave side
// is the execute stage itself.
interface ex_stage_if;

   logic        flush;
   logic        in_valid;
   logic [3:0]  alu_fun;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] store_data;
   logic [4:0]  write_reg;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        lu_op;
   logic [1:0]  mem_to_reg;
   logic [31:0] pc_plus4;
   logic [31:0] lu_data;
   logic [2:0]  md_op;
   logic [1:0]  mf_sel;

   logic        stall;
   logic [31:0] ex_mem_alu_s;
   logic [31:0] ex_mem_wdata;
   logic [31:0] ex_mem_pc_plus4;
   logic [31:0] ex_mem_lu_data;
   logic [4:0]  ex_mem_write_reg;
   logic        ex_mem_mem_read;
   logic        ex_mem_mem_write;
   logic        ex_mem_reg_write;
   logic        ex_mem_lu_op;
   logic [1:0]  ex_mem_mem_to_reg;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output flush, in_valid, alu_fun, op_a, op_b, store_data, write_reg,
             mem_read, mem_write, reg_write, lu_op, mem_to_reg, pc_plus4,
             lu_data, md_op, mf_sel,
      input  stall, ex_mem_alu_s, ex_mem_wdata, ex_mem_pc_plus4, ex_mem_lu_data,
             ex_mem_write_reg, ex_mem_mem_read, ex_mem_mem_write,
             ex_mem_reg_write, ex_mem_lu_op, ex_mem_mem_to_reg, hi, lo
   );

   modport slave (
      input  flush, in_valid, alu_fun, op_a, op_b, store_data, write_reg,
             mem_read, mem_write, reg_write, lu_op, mem_to_reg, pc_plus4,
             lu_data, md_op, mf_sel,
      output stall, ex_mem_alu_s, ex_mem_wdata, ex_mem_pc_plus4, ex_mem_lu_data,
             ex_mem_write_reg, ex_mem_mem_read, ex_mem_mem_write,
             ex_mem_reg_write, ex_mem_lu_op, ex_mem_mem_to_reg, hi, lo
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide with HI/LO registers.
// Signed ops run on magnitudes and fix the signs when the result is written.
// The start edge already performs the first step, so an op occupies BUSY for
// MULDIV_CYCLES-1 cycles and HI/LO are valid MULDIV_CYCLES cycles after the
// start cycle; count holds the number of steps completed.
module muldiv_unit
   import cpu_defs::*;
#(
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [4:0] LAST_STEP = 5'(MULDIV_CYCLES - 1);

   md_state_e   state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] acc_q;       // partial product high half / partial remainder
   logic [31:0] opr_q;       // multiplier shifting out / dividend -> quotient
   logic [31:0] dvs_q;       // multiplicand / divisor magnitude
   logic        is_div_q;
   logic        neg_res_q;   // negate product or quotient
   logic        neg_rem_q;   // negate remainder (dividend was negative)
   logic        div_zero_q;
   logic [31:0] hi_q, lo_q;

   logic        signed_op, is_div_in, take_start, finish;
   logic [31:0] mag_a, mag_b;
   logic [31:0] st_acc, st_opr, st_dvs;
   logic        st_div;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic [31:0] nxt_acc, nxt_opr;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   assign busy       = (state_q == MD_BUSY);
   assign signed_op  = ~op[0];
   assign is_div_in  = op[1];
   assign take_start = start & op[2] & ~busy;
   assign mag_a      = (signed_op & a[31]) ? (~a + 32'd1) : a;
   assign mag_b      = (signed_op & b[31]) ? (~b + 32'd1) : b;

   // Step operands: fresh magnitudes on the start edge, registers while BUSY.
   assign st_acc = busy ? acc_q    : 32'd0;
   assign st_opr = busy ? opr_q    : mag_a;
   assign st_dvs = busy ? dvs_q    : mag_b;
   assign st_div = busy ? is_div_q : is_div_in;

   // One radix-2 step: shift-add for multiply, restoring subtract for divide.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      mul_sum   = {1'b0, st_acc} + (st_opr[0] ? {1'b0, st_dvs} : 33'd0);
      div_shift = {st_acc, st_opr[31]};
      div_diff  = div_shift - {1'b0, st_dvs};
      nxt_acc   = mul_sum[32:1];
      nxt_opr   = {mul_sum[0], st_opr[31:1]};
      if (st_div) begin
         if (!div_diff[32]) begin
            nxt_acc = div_diff[31:0];
            nxt_opr = {st_opr[30:0], 1'b1};
         end else begin
            nxt_acc = div_shift[31:0];
            nxt_opr = {st_opr[30:0], 1'b0};
         end
      end
   end

   // Sign correction of the final step's result.
   always_comb begin
      prod_fix = {nxt_acc, nxt_opr};
      if (neg_res_q) prod_fix = ~prod_fix + 64'd1;
      quo_fix = neg_res_q ? (~nxt_opr + 32'd1) : nxt_opr;
      if (div_zero_q) quo_fix = '1;
      rem_fix = neg_rem_q ? (~nxt_acc + 32'd1) : nxt_acc;
   end

   // FSM next state and step counter.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      finish  = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (take_start) begin
               state_d = MD_BUSY;
               count_d = 5'd1;
            end
         end
         MD_BUSY: begin
            count_d = count_q + 5'd1;
            if (count_q == LAST_STEP) begin
               state_d = MD_IDLE;
               count_d = '0;
               finish  = 1'b1;
            end
         end
         default: begin
            state_d = MD_IDLE;
            count_d = '0;
         end
      endcase
   end

   // FSM state register; reset aborts any op in flight.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= MD_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Operand/accumulator registers and result sign flags.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         acc_q      <= '0;
         opr_q      <= '0;
         dvs_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else if (take_start) begin
         acc_q      <= nxt_acc;
         opr_q      <= nxt_opr;
         dvs_q      <= mag_b;
         is_div_q   <= is_div_in;
         neg_res_q  <= signed_op & (a[31] ^ b[31]);
         neg_rem_q  <= signed_op & a[31];
         div_zero_q <= is_div_in & (b == 32'd0);
      end else if (busy) begin
         acc_q <= nxt_acc;
         opr_q <= nxt_opr;
      end
   end

   // HI/LO are written on the edge that completes the last step.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (finish) begin
         hi_q <= is_div_q ? rem_fix : prod_fix[63:32];
         lo_q <= is_div_q ? quo_fix : prod_fix[31:0];
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO move mux, HI/LO hazard stall and the EX/MEM
// pipeline register; multiply/divide is delegated to muldiv_unit.
module ex_stage
   import cpu_defs::*;
#(
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset_b,
   ex_stage_if.slave  bus
);

   logic        md_busy, md_start, bubble;
   logic [31:0] alu_y, result;
   logic [31:0] md_hi, md_lo;
   ex_mem_t     ex_mem_d, ex_mem_q;

   assign alu_y = alu_eval(bus.alu_fun, bus.op_a, bus.op_b);

   // Only instructions touching HI/LO wait for the unit to drain.
   assign bus.stall = md_busy & bus.in_valid & (bus.md_op[2] | (bus.mf_sel != MF_ALU));
   assign bubble    = bus.stall | bus.flush;
   assign md_start  = bus.in_valid & bus.md_op[2] & ~bus.flush & ~bus.stall;

   muldiv_unit #(
      .MULDIV_CYCLES (MULDIV_CYCLES)
   ) u_muldiv (
      .clk     (clk),
      .reset_b (reset_b),
      .start   (md_start),
      .op      (bus.md_op),
      .a       (bus.op_a),
      .b       (bus.op_b),
      .busy    (md_busy),
      .hi      (md_hi),
      .lo      (md_lo)
   );

   // Result mux: MFHI / MFLO read the architectural registers.
   always_comb begin
      result = alu_y;
      case (bus.mf_sel)
         MF_HI:   result = md_hi;
         MF_LO:   result = md_lo;
         default: result = alu_y;
      endcase
   end

   // Next EX/MEM entry: a bubble on stall or flush, else the current instruction.
   always_comb begin
      ex_mem_d = EX_MEM_BUBBLE;
      if (!bubble) begin
         ex_mem_d.alu_s      = result;
         ex_mem_d.wdata      = bus.store_data;
         ex_mem_d.write_reg  = bus.write_reg;
         ex_mem_d.mem_read   = bus.mem_read;
         ex_mem_d.mem_write  = bus.mem_write;
         ex_mem_d.reg_write  = bus.reg_write;
         ex_mem_d.mem_to_reg = bus.mem_to_reg;
         ex_mem_d.pc_plus4   = bus.pc_plus4;
         ex_mem_d.lu_op      = bus.lu_op;
         ex_mem_d.lu_data    = bus.lu_data;
      end
   end

   // EX/MEM pipeline register.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) ex_mem_q <= EX_MEM_BUBBLE;
      else          ex_mem_q <= ex_mem_d;
   end

   assign bus.ex_mem_alu_s      = ex_mem_q.alu_s;
   assign bus.ex_mem_wdata      = ex_mem_q.wdata;
   assign bus.ex_mem_write_reg  = ex_mem_q.write_reg;
   assign bus.ex_mem_mem_read   = ex_mem_q.mem_read;
   assign bus.ex_mem_mem_write  = ex_mem_q.mem_write;
   assign bus.ex_mem_reg_write  = ex_mem_q.reg_write;
   assign bus.ex_mem_mem_to_reg = ex_mem_q.mem_to_reg;
   assign bus.ex_mem_pc_plus4   = ex_mem_q.pc_plus4;
   assign bus.ex_mem_lu_op      = ex_mem_q.lu_op;
   assign bus.ex_mem_lu_data    = ex_mem_q.lu_data;
   assign bus.hi                = md_hi;
   assign bus.lo                = md_lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU vectors, mult/div results and timing,
// stall/flush behaviour and asynchronous reset in the middle of an op.
module tb_ex_stage;
   import cpu_defs::*;

   logic clk = 1'b0;
   logic reset_b;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ex_stage_if bus();

   ex_stage #(.MULDIV_CYCLES(32)) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus)
   );

   typedef struct {
      logic [3:0]  fun;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } alu_vec_t;

   alu_vec_t alu_vecs[14] = '{
      '{ALU_ADD,  32'd5,        32'd7,        32'd12},
      '{ALU_SUB,  32'd5,        32'd7,        32'hFFFF_FFFE},
      '{ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000},
      '{ALU_OR,   32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF},
      '{ALU_XOR,  32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0},
      '{ALU_NOR,  32'd0,        32'd0,        32'hFFFF_FFFF},
      '{ALU_SLL,  32'd4,        32'd1,        32'h0000_0010},
      '{ALU_SLL,  32'h24,       32'd1,        32'h0000_0010},
      '{ALU_SRL,  32'd4,        32'h8000_0000, 32'h0800_0000},
      '{ALU_SRA,  32'd4,        32'h8000_0000, 32'hF800_0000},
      '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1},
      '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0},
      '{ALU_ADD,  32'hFFFF_FFFF, 32'd1,       32'd0},
      '{4'd15,    32'd9,        32'd9,        32'd0}
   };

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.alu_fun    = '0;
      bus.op_a       = '0;
      bus.op_b       = '0;
      bus.store_data = '0;
      bus.write_reg  = '0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.lu_op      = 1'b0;
      bus.mem_to_reg = '0;
      bus.pc_plus4   = '0;
      bus.lu_data    = '0;
      bus.md_op      = MD_NONE;
      bus.mf_sel     = MF_ALU;
   endtask

   task automatic drive_alu(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.alu_fun  = fun;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.md_op    = MD_NONE;
      bus.mf_sel   = MF_ALU;
   endtask

   task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      idle_inputs();
      bus.in_valid = 1'b1;
      bus.md_op    = op;
      bus.op_a     = a;
      bus.op_b     = b;
   endtask

   task automatic drive_mf(input logic [1:0] sel, input logic [4:0] rd);
      idle_inputs();
      bus.in_valid  = 1'b1;
      bus.mf_sel    = sel;
      bus.reg_write = 1'b1;
      bus.write_reg = rd;
   endtask

   // Counts consecutive stalled cycles of the instruction currently driven.
   task automatic wait_stall(output int n);
      n = 0;
      #1;
      while (bus.stall === 1'b1 && n < 64) begin
         n++;
         tick();
      end
   endtask

   // Issue a mult/div, follow it with MFLO, and check stall length and results.
   task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      drive_md(op, a, b);
      tick();
      drive_mf(MF_LO, 5'd2);
      wait_stall(n);
      check({tag, " stall_cycles"}, 32'(n), 32'd31);
      check({tag, " hi"}, bus.hi, exp_hi);
      check({tag, " lo"}, bus.lo, exp_lo);
      tick();
      check({tag, " mflo"}, bus.ex_mem_alu_s, exp_lo);
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      int n;
      reset_b = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("reset stall", {31'd0, bus.stall}, 32'd0);
      check("reset alu_s", bus.ex_mem_alu_s, 32'd0);
      check("reset reg_write", {31'd0, bus.ex_mem_reg_write}, 32'd0);
      check("reset hi", bus.hi, 32'd0);
      check("reset lo", bus.lo, 32'd0);
      @(negedge clk);
      reset_b = 1'b1;
      tick();

      // ALU vectors, one per cycle, each visible one edge later.
      foreach (alu_vecs[i]) begin
         idle_inputs();
         drive_alu(alu_vecs[i].fun, alu_vecs[i].a, alu_vecs[i].b);
         tick();
         check($sformatf("alu[%0d]", i), bus.ex_mem_alu_s, alu_vecs[i].exp);
      end

      // Passthrough of every EX/MEM field.
      idle_inputs();
      drive_alu(ALU_ADD, 32'd5, 32'd7);
      bus.store_data = 32'hCAFE_0001;
      bus.write_reg  = 5'd17;
      bus.reg_write  = 1'b1;
      bus.mem_to_reg = 2'b10;
      bus.pc_plus4   = 32'h0040_0104;
      bus.lu_op      = 1'b1;
      bus.lu_data    = 32'h1234_0000;
      tick();
      check("pass alu_s", bus.ex_mem_alu_s, 32'd12);
      check("pass wdata", bus.ex_mem_wdata, 32'hCAFE_0001);
      check("pass write_reg", {27'd0, bus.ex_mem_write_reg}, 32'd17);
      check("pass reg_write", {31'd0, bus.ex_mem_reg_write}, 32'd1);
      check("pass mem_to_reg", {30'd0, bus.ex_mem_mem_to_reg}, 32'd2);
      check("pass pc_plus4", bus.ex_mem_pc_plus4, 32'h0040_0104);
      check("pass lu_op", {31'd0, bus.ex_mem_lu_op}, 32'd1);
      check("pass lu_data", bus.ex_mem_lu_data, 32'h1234_0000);

      // Mult/div results and MFLO stall timing.
      run_md("mult -3*5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_md("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      run_md("divu 7/0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
      run_md("div -9/0", MD_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
      run_md("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
      run_md("divu big", MD_DIVU, 32'hFFFF_FFF0, 32'd16, 32'd0, 32'h0FFF_FFFF);

      // Independent ADD and LW during BUSY pass through; a second MULT waits.
      drive_md(MD_MULT, 32'd6, 32'd7);
      tick();
      idle_inputs();
      drive_alu(ALU_ADD, 32'd1, 32'd2);
      bus.reg_write = 1'b1;
      bus.write_reg = 5'd4;
      #1;
      check("busy add stall", {31'd0, bus.stall}, 32'd0);
      tick();
      check("busy add alu_s", bus.ex_mem_alu_s, 32'd3);
      check("busy add reg_write", {31'd0, bus.ex_mem_reg_write}, 32'd1);
      idle_inputs();
      drive_alu(ALU_ADD, 32'd100, 32'd4);
      bus.mem_read   = 1'b1;
      bus.mem_to_reg = 2'b01;
      bus.reg_write  = 1'b1;
      bus.write_reg  = 5'd9;
      #1;
      check("busy lw stall", {31'd0, bus.stall}, 32'd0);
      tick();
      check("busy lw alu_s", bus.ex_mem_alu_s, 32'd104);
      check("busy lw mem_read", {31'd0, bus.ex_mem_mem_read}, 32'd1);
      check("busy lw mem_to_reg", {30'd0, bus.ex_mem_mem_to_reg}, 32'd1);
      check("busy lw write_reg", {27'd0, bus.ex_mem_write_reg}, 32'd9);
      drive_md(MD_MULT, 32'd2, 32'd3);
      wait_stall(n);
      check("b2b mult stall_cycles", 32'(n), 32'd29);
      check("b2b first lo", bus.lo, 32'd42);
      check("b2b first hi", bus.hi, 32'd0);
      tick();
      drive_mf(MF_LO, 5'd5);
      wait_stall(n);
      check("b2b second stall_cycles", 32'(n), 32'd31);
      check("b2b second lo", bus.lo, 32'd6);
      idle_inputs();

      // Flush turns an instruction into a bubble and suppresses a start.
      drive_alu(ALU_ADD, 32'd1, 32'd1);
      bus.reg_write = 1'b1;
      bus.mem_write = 1'b1;
      bus.flush     = 1'b1;
      tick();
      check("flush reg_write", {31'd0, bus.ex_mem_reg_write}, 32'd0);
      check("flush mem_write", {31'd0, bus.ex_mem_mem_write}, 32'd0);
      check("flush alu_s", bus.ex_mem_alu_s, 32'd0);
      drive_md(MD_MULT, 32'd9, 32'd9);
      bus.flush = 1'b1;
      tick();
      drive_mf(MF_LO, 5'd3);
      #1;
      check("flushed mult stall", {31'd0, bus.stall}, 32'd0);
      tick();
      check("flushed mult mflo", bus.ex_mem_alu_s, 32'd6);
      idle_inputs();
      repeat (35) tick();
      check("flushed mult lo", bus.lo, 32'd6);
      check("flushed mult hi", bus.hi, 32'd0);

      // Flush during BUSY does not abort the committed op.
      drive_md(MD_MULT, 32'd4, 32'd5);
      tick();
      idle_inputs();
      bus.flush = 1'b1;
      tick();
      drive_mf(MF_LO, 5'd3);
      wait_stall(n);
      check("busy flush stall_cycles", 32'(n), 32'd30);
      check("busy flush lo", bus.lo, 32'd20);
      idle_inputs();

      // Asynchronous reset about ten cycles into an op.
      drive_md(MD_MULTU, 32'd3, 32'd3);
      tick();
      idle_inputs();
      repeat (9) tick();
      drive_alu(ALU_ADD, 32'h11, 32'h22);
      bus.reg_write = 1'b1;
      bus.write_reg = 5'd6;
      tick();
      check("pre-reset alu_s", bus.ex_mem_alu_s, 32'h33);
      drive_mf(MF_LO, 5'd7);
      #1;
      check("pre-reset stall", {31'd0, bus.stall}, 32'd1);
      #2;
      reset_b = 1'b0;
      #1;
      check("mid reset stall", {31'd0, bus.stall}, 32'd0);
      check("mid reset alu_s", bus.ex_mem_alu_s, 32'd0);
      check("mid reset reg_write", {31'd0, bus.ex_mem_reg_write}, 32'd0);
      check("mid reset write_reg", {27'd0, bus.ex_mem_write_reg}, 32'd0);
      check("mid reset hi", bus.hi, 32'd0);
      check("mid reset lo", bus.lo, 32'd0);
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      reset_b = 1'b1;
      tick();
      run_md("mult after reset", MD_MULT, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
